// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone sample feeder.
package tone_pkg;

  localparam int unsigned DefDataW = 24;
  localparam int unsigned DefHpW   = 16;

  typedef enum logic [1:0] {
    StSilent  = 2'd0,
    StPlay    = 2'd1,
    StRelease = 2'd2
  } tone_state_e;

  // Two's-complement negation on a wide container; callers truncate to their width.
  function automatic logic [31:0] tone_negate(input logic [31:0] mag);
    return ~mag + 32'd1;
  endfunction

endpackage

// File: rtl/tone_envelope.sv
// Amplitude ramp register: loads on note start, steps up toward a target or down toward 0,
// saturating at both ends. Used by tone_sample_feeder only when TONE_ENVELOPE_EN is defined.
module tone_envelope #(
  parameter int unsigned MAG_W    = 23,
  parameter int unsigned ENV_STEP = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic [MAG_W-1:0] target_i,
  output logic [MAG_W-1:0] env_q_o,
  output logic [MAG_W-1:0] env_d_o
);

  localparam logic [MAG_W-1:0] Step = MAG_W'(ENV_STEP);

  logic [MAG_W-1:0] env_q, env_d;

  always_comb begin
    env_d = env_q;
    if (start_i) begin
      env_d = (target_i <= Step) ? target_i : Step;
    end else if (up_i) begin
      // Also clamps down if the target was lowered at a boundary.
      env_d = (env_q >= target_i || (target_i - env_q) <= Step) ? target_i : env_q + Step;
    end else if (down_i) begin
      env_d = (env_q <= Step) ? '0 : env_q - Step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      env_q <= '0;
    end else begin
      env_q <= env_d;
    end
  end

  assign env_q_o = env_q;
  assign env_d_o = env_d;

endmodule

// File: rtl/tone_sample_feeder.sv
// Square-wave tone source feeding the codec write port, one sample per accepted write.
// Optional amplitude envelope enabled by defining TONE_ENVELOPE_EN.
module tone_sample_feeder
  import tone_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned HP_W     = DefHpW,
  parameter int unsigned ENV_STEP = 64
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              note_on,
  input  logic [HP_W-1:0]   half_period,
  input  logic [DATA_W-2:0] amplitude,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              playing
);

  localparam int unsigned MagW = DATA_W - 1;

  function automatic logic [DATA_W-1:0] make_sample(input logic pol, input logic [MagW-1:0] mag);
    logic [DATA_W-1:0] pos;
    pos = {1'b0, mag};
    return pol ? DATA_W'(tone_negate(32'(pos))) : pos;
  endfunction

  tone_state_e       state_q, state_d, run_st;
  logic [HP_W-1:0]   cnt_q, cnt_d, hp_q, hp_d;
  logic              pol_q, pol_d;
  logic [MagW-1:0]   amp_q, amp_d, mag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept, boundary, start;
  logic              rel_idle, release_end;

  assign write    = write_ready & ~reset;
  assign accept   = write;
  assign boundary = (cnt_q == hp_q - HP_W'(1));

`ifdef TONE_ENVELOPE_EN
  logic [MagW-1:0] env_q, env_d;

  tone_envelope #(
    .MAG_W   (MagW),
    .ENV_STEP(ENV_STEP)
  ) u_envelope (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .start_i (start),
    .up_i    (accept && (state_d == StPlay)),
    .down_i  (accept && (state_d == StRelease)),
    .target_i(amp_d),
    .env_q_o (env_q),
    .env_d_o (env_d)
  );

  assign rel_idle    = (env_q == '0);
  // Release ends at the first boundary whose step takes the envelope to zero.
  assign release_end = boundary && (env_q <= MagW'(ENV_STEP));
  assign mag_d       = env_d;
`else
  assign rel_idle    = 1'b0;
  assign release_end = boundary;
  assign mag_d       = amp_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pol_d   = pol_q;
    hp_d    = hp_q;
    amp_d   = amp_q;
    start   = 1'b0;
    run_st  = note_on ? StPlay : StRelease;
    unique case (state_q)
      StSilent: begin
        if (note_on && (half_period != '0)) begin
          start   = 1'b1;
          state_d = StPlay;
          hp_d    = half_period;
          amp_d   = amplitude;
          cnt_d   = '0;
          pol_d   = 1'b0;
        end
      end
      StPlay, StRelease: begin
        // note_on is honoured every cycle; the accept then follows the new state's rules.
        state_d = run_st;
        if ((run_st == StRelease) && rel_idle) begin
          state_d = StSilent;
        end else if (accept) begin
          if (!boundary) begin
            cnt_d = cnt_q + HP_W'(1);
          end else if ((run_st == StRelease) && release_end) begin
            state_d = StSilent;
          end else begin
            cnt_d = '0;
            pol_d = ~pol_q;
            hp_d  = half_period;
            amp_d = amplitude;
            if (half_period == '0) begin
              state_d = StSilent;
            end
          end
        end
      end
      default: state_d = StSilent;
    endcase
    if (state_d == StSilent) begin
      cnt_d = '0;
      pol_d = 1'b0;
    end
  end

  always_comb begin
    data_d = data_q;
    if (state_d == StSilent) begin
      data_d = '0;
    end else if (accept || start) begin
      data_d = make_sample(pol_d, mag_d);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StSilent;
      cnt_q   <= '0;
      pol_q   <= 1'b0;
      hp_q    <= '0;
      amp_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol_d;
      hp_q    <= hp_d;
      amp_q   <= amp_d;
      data_q  <= data_d;
    end
  end

  assign writedata_left  = data_q;
  assign writedata_right = data_q;
  assign playing         = (state_q != StSilent);

endmodule

// File: tb/tb_tone_sample_feeder.sv
// Directed bench for tone_sample_feeder: per-cycle vector table plus a backpressure sequence.
module tb_tone_sample_feeder;

  localparam logic [23:0] P  = 24'h000100;
  localparam logic [23:0] N  = 24'hFFFF00;
  localparam logic [23:0] P2 = 24'h000200;
  localparam logic [23:0] N2 = 24'hFFFE00;

  logic        clk = 1'b0;
  logic        rst, note_on, wr, write, playing;
  logic [15:0] hp;
  logic [22:0] amp;
  logic [23:0] dl, dr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tone_sample_feeder dut (
    .CLOCK_50       (clk),
    .reset          (rst),
    .note_on        (note_on),
    .half_period    (hp),
    .amplitude      (amp),
    .write_ready    (wr),
    .write          (write),
    .writedata_left (dl),
    .writedata_right(dr),
    .playing        (playing)
  );

  typedef struct packed {
    logic        rst;
    logic        non;
    logic [15:0] hp;
    logic [22:0] amp;
    logic        wr;
    logic        e_write;
    logic [23:0] e_data;
    logic        e_play;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic n, input logic [15:0] h, input logic [22:0] a,
                   input logic w, input logic ew, input logic [23:0] ed, input logic ep);
    vec_t t;
    t = '{rst: r, non: n, hp: h, amp: a, wr: w, e_write: ew, e_data: ed, e_play: ep};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] bp_expect(input int k);
    if (k == 0) return 24'h0;
    return ((((k - 1) / 4) % 2) == 0) ? P : N;
  endfunction

  initial begin
    logic        prev_wr;
    logic [23:0] prev_data;
    int          acc;

    // Reset, basic tone (hp=4, amp=0x100)
    v(1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 4, 23'h100, 1, 1, 0, 0);
    repeat (4) v(0, 1, 4, 23'h100, 1, 1, P, 1);
    repeat (4) v(0, 1, 4, 23'h100, 1, 1, N, 1);
    repeat (4) v(0, 1, 4, 23'h100, 1, 1, P, 1);
    repeat (2) v(0, 1, 4, 23'h100, 1, 1, N, 1);
    // Release after two negative samples: half completes, then silence
    repeat (2) v(0, 0, 4, 23'h100, 1, 1, N, 1);
    repeat (2) v(0, 0, 4, 23'h100, 1, 1, 0, 0);
    // Restart, then relatch hp=2/amp=0x200 mid negative half
    v(0, 1, 4, 23'h100, 1, 1, 0, 0);
    repeat (4) v(0, 1, 4, 23'h100, 1, 1, P, 1);
    v(0, 1, 4, 23'h100, 1, 1, N, 1);
    repeat (3) v(0, 1, 2, 23'h200, 1, 1, N, 1);
    repeat (2) v(0, 1, 2, 23'h200, 1, 1, P2, 1);
    repeat (2) v(0, 1, 2, 23'h200, 1, 1, N2, 1);
    v(0, 1, 2, 23'h200, 1, 1, P2, 1);
    // Stall holds data and counter
    repeat (2) v(0, 1, 2, 23'h200, 0, 0, P2, 1);
    v(0, 1, 2, 23'h200, 1, 1, P2, 1);
    v(0, 1, 2, 23'h200, 1, 1, N2, 1);
    // half_period=1 toggles every accept; half_period=0 at a boundary silences
    v(0, 1, 1, 23'h200, 1, 1, N2, 1);
    v(0, 1, 1, 23'h200, 1, 1, P2, 1);
    v(0, 1, 1, 23'h200, 1, 1, N2, 1);
    v(0, 1, 1, 23'h200, 1, 1, P2, 1);
    v(0, 1, 0, 23'h200, 1, 1, N2, 1);
    v(0, 1, 0, 23'h200, 1, 1, 0, 0);
    // Reset mid-play with note_on held high
    v(0, 1, 4, 23'h100, 1, 1, 0, 0);
    repeat (2) v(0, 1, 4, 23'h100, 1, 1, P, 1);
    v(1, 1, 4, 23'h100, 1, 0, P, 1);
    v(0, 1, 4, 23'h100, 1, 1, 0, 0);
    repeat (2) v(0, 1, 4, 23'h100, 1, 1, P, 1);
    // Release then re-trigger before the boundary: tone continues uninterrupted
    v(0, 0, 4, 23'h100, 1, 1, P, 1);
    v(0, 1, 4, 23'h100, 1, 1, P, 1);
    repeat (2) v(0, 1, 4, 23'h100, 1, 1, N, 1);

    rst = 1'b1; note_on = 1'b0; hp = '0; amp = '0; wr = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; note_on = vecs[i].non; hp = vecs[i].hp;
      amp = vecs[i].amp; wr = vecs[i].wr;
      #2;
      check($sformatf("vec%0d write", i), 32'(write), 32'(vecs[i].e_write));
      check($sformatf("vec%0d left", i), 32'(dl), 32'(vecs[i].e_data));
      check($sformatf("vec%0d right", i), 32'(dr), 32'(vecs[i].e_data));
      check($sformatf("vec%0d playing", i), 32'(playing), 32'(vecs[i].e_play));
    end

    // Backpressure: write_ready toggles every 3 cycles; accepted stream must match basic tone.
    @(negedge clk);
    rst = 1'b1; note_on = 1'b0; wr = 1'b1;
    @(negedge clk);
    rst = 1'b0; note_on = 1'b1; hp = 16'd4; amp = 23'h100;
    acc = 0;
    prev_wr = 1'b1;
    prev_data = '0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      wr = (((c / 3) % 2) == 0);
      #2;
      check($sformatf("bp%0d write", c), 32'(write), 32'(wr));
      if (!prev_wr) check($sformatf("bp%0d hold", c), 32'(dl), 32'(prev_data));
      if (write) begin
        check($sformatf("bp acc%0d", acc), 32'(dl), 32'(bp_expect(acc)));
        acc++;
      end
      prev_wr = wr;
      prev_data = dl;
    end
    check("bp accept count", 32'(acc), 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
